// File: rtl/sysctrl_pkg.sv
// Shared definitions for the sysctrl byte protocol: command codes, the
// STATUS signature bytes, the initiator state encoding and a small helper.
package sysctrl_pkg;

    localparam logic [7:0] CMD_STATUS  = 8'd0;
    localparam logic [7:0] CMD_LEDS    = 8'd1;
    localparam logic [7:0] CMD_COLOR   = 8'd2;
    localparam logic [7:0] CMD_BUTTONS = 8'd3;
    localparam logic [7:0] CMD_CONFIG  = 8'd4;
    localparam logic [7:0] CMD_INT     = 8'd5;
    localparam logic [7:0] CMD_INTSRC  = 8'd6;

    localparam logic [7:0] STATUS_SIG0 = 8'h5c;
    localparam logic [7:0] STATUS_SIG1 = 8'h42;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_GAP,
        ST_LOAD,
        ST_SEND,
        ST_FIN
    } init_state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sysctrl_initiator_if.sv
// Request / payload / response / bus bundle of the sysctrl initiator.
//   master : the initiator (drives req_ready, wr_ready, rd_*, done, err, bus_*)
//   slave  : the surrounding logic and responder (drives req_*, wr_*, bus_din)
interface sysctrl_initiator_if;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_cmd;
    logic [3:0] req_len;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       done;
    logic       err;
    logic       bus_strobe;
    logic       bus_start;
    logic [7:0] bus_dout;
    logic [7:0] bus_din;

    modport master (
        input  req_valid, req_cmd, req_len, wr_valid, wr_data, bus_din,
        output req_ready, wr_ready, rd_valid, rd_data, done, err,
               bus_strobe, bus_start, bus_dout
    );

    modport slave (
        output req_valid, req_cmd, req_len, wr_valid, wr_data, bus_din,
        input  req_ready, wr_ready, rd_valid, rd_data, done, err,
               bus_strobe, bus_start, bus_dout
    );
endinterface

// File: rtl/sysctrl_gap_timer.sv
// Loadable down-counter. i_load writes i_value; otherwise the count drops by
// one per cycle and rests at zero. o_last is high during the final counted
// cycle (count == 1), so a value of N spans exactly N cycles after the load.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_load, i_value: load strobe and start value
//   o_last         : final-cycle flag
module sysctrl_gap_timer #(
    parameter int W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_last
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_value;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_last = (r_cnt == {{(W-1){1'b0}}, 1'b1});
endmodule

// File: rtl/sysctrl_initiator.sv
// Initiator end of the sysctrl byte protocol: frames a command byte, req_len
// payload bytes and the matching response bytes on the strobe/start bus.
//   clk, reset_n : clock, async active-low reset
//   io (master)  : req_* request, wr_* payload in, rd_* response out,
//                  done/err frame end, bus_* toward the responder
// Optional feature macro SYSCTRL_INIT_TIMEOUT_EN: abort a frame with done+err
// when a payload byte stalls WR_TIMEOUT cycles in LOAD.
module sysctrl_initiator
    import sysctrl_pkg::*;
#(
    parameter int GAP_CYCLES = 4,
    parameter int WR_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    sysctrl_initiator_if.master  io
);

`ifdef SYSCTRL_INIT_TIMEOUT_EN
    localparam int TW = $clog2(max2(GAP_CYCLES + 1, WR_TIMEOUT) + 1);
    localparam logic [TW-1:0] TMO_VAL = TW'(WR_TIMEOUT);
`else
    localparam int TW = $clog2(GAP_CYCLES + 2);
`endif
    // Every byte slot is GAP_CYCLES + 2 cycles (strobe, gap, load). The gap
    // that closes the frame runs one cycle longer in place of the LOAD cycle,
    // so done lands one full slot after the last strobe.
    localparam logic [TW-1:0] GAP_MID = TW'(GAP_CYCLES);
    localparam logic [TW-1:0] GAP_END = TW'(GAP_CYCLES + 1);

    if (GAP_CYCLES < 2 || WR_TIMEOUT < 1) begin : g_param_err
        $error("sysctrl_initiator: GAP_CYCLES must be >= 2 and WR_TIMEOUT >= 1");
    end

    init_state_t r_state, w_next;
    logic [3:0]  r_len, r_sent;
    logic [7:0]  r_dout, r_rd_data;
    logic [1:0]  r_vld_pipe;
    logic        w_tmr_load, w_tmr_last;
    logic [TW-1:0] w_tmr_val;
    logic        w_more;

    // After the current SEND, is there still a payload byte to go?
    assign w_more = ({1'b0, r_sent} + 5'd1) < {1'b0, r_len};

    sysctrl_gap_timer #(.W(TW)) u_tmr (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_load  (w_tmr_load),
        .i_value (w_tmr_val),
        .o_last  (w_tmr_last)
    );

    always_comb begin
        w_next     = r_state;
        w_tmr_load = 1'b0;
        w_tmr_val  = GAP_MID;
        case (r_state)
            ST_IDLE: if (io.req_valid) w_next = ST_CMD;
            ST_CMD: begin
                w_next     = ST_GAP;
                w_tmr_load = 1'b1;
                w_tmr_val  = (r_len != 4'd0) ? GAP_MID : GAP_END;
            end
            ST_GAP: begin
                if (w_tmr_last) begin
                    if (r_sent < r_len) begin
                        w_next = ST_LOAD;
`ifdef SYSCTRL_INIT_TIMEOUT_EN
                        w_tmr_load = 1'b1;
                        w_tmr_val  = TMO_VAL;
`endif
                    end else begin
                        w_next = ST_FIN;
                    end
                end
            end
            ST_LOAD: begin
                if (io.wr_valid)
                    w_next = ST_SEND;
`ifdef SYSCTRL_INIT_TIMEOUT_EN
                else if (w_tmr_last)
                    w_next = ST_FIN;
`endif
            end
            ST_SEND: begin
                w_next     = ST_GAP;
                w_tmr_load = 1'b1;
                w_tmr_val  = w_more ? GAP_MID : GAP_END;
            end
            ST_FIN:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_len   <= 4'd0;
            r_sent  <= 4'd0;
            r_dout  <= 8'h00;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: if (io.req_valid) begin
                    r_len  <= io.req_len;
                    r_dout <= io.req_cmd;
                    r_sent <= 4'd0;
                end
                ST_LOAD: if (io.wr_valid) r_dout <= io.wr_data;
                ST_SEND: r_sent <= r_sent + 4'd1;
                default: ;
            endcase
        end
    end

    // Response capture: the responder registers data_out on the strobe edge,
    // so bus_din is sampled one cycle later and presented one cycle after that.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld_pipe <= 2'b00;
            r_rd_data  <= 8'h00;
        end else begin
            r_vld_pipe <= {r_vld_pipe[0], (r_state == ST_SEND)};
            if (r_vld_pipe[0]) r_rd_data <= io.bus_din;
        end
    end

`ifdef SYSCTRL_INIT_TIMEOUT_EN
    logic r_to;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_to <= 1'b0;
        else if (r_state == ST_IDLE)
            r_to <= 1'b0;
        else if (r_state == ST_LOAD && !io.wr_valid && w_tmr_last)
            r_to <= 1'b1;
    end
    assign io.err = (r_state == ST_FIN) && r_to;
`else
    assign io.err = 1'b0;
`endif

    assign io.req_ready  = (r_state == ST_IDLE);
    assign io.wr_ready   = (r_state == ST_LOAD);
    assign io.bus_strobe = (r_state == ST_CMD) || (r_state == ST_SEND);
    assign io.bus_start  = (r_state == ST_CMD);
    assign io.bus_dout   = r_dout;
    assign io.done       = (r_state == ST_FIN);
    assign io.rd_valid   = r_vld_pipe[1];
    assign io.rd_data    = r_rd_data;

endmodule

// File: tb/tb_sysctrl_initiator.sv
// Bench for sysctrl_initiator: responder model on the bus, directed table of
// frames, reset-mid-frame and timeout sequences, and randomized frames checked
// against a slot-timing reference model.
module tb_sysctrl_initiator;
    import sysctrl_pkg::*;

    localparam int G   = 4;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    sysctrl_initiator_if sif();

    sysctrl_initiator #(.GAP_CYCLES(G), .WR_TIMEOUT(TMO)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .io      (sif)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- responder model ----------------
    function automatic logic [7:0] resp_byte(input logic [7:0] cmd, input int idx,
                                             input logic [7:0] wbyte);
        if (cmd == CMD_STATUS) begin
            case (idx)
                0:       return STATUS_SIG0;
                1:       return STATUS_SIG1;
                2:       return 8'h02;
                default: return 8'h00;
            endcase
        end
        return wbyte;   // write commands echo the byte just received
    endfunction

    logic [7:0] rs_cmd;
    int         rs_idx;
    logic       rs_released;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sif.bus_din <= 8'h00;
            rs_cmd      <= 8'h00;
            rs_idx      <= 0;
            rs_released <= 1'b0;
        end else if (sif.bus_strobe) begin
            if (sif.bus_start) begin
                rs_cmd <= sif.bus_dout;
                rs_idx <= 0;
            end else begin
                sif.bus_din <= resp_byte(rs_cmd, rs_idx, sif.bus_dout);
                rs_idx      <= rs_idx + 1;
                if (rs_cmd == CMD_CONFIG && rs_idx == 0 && sif.bus_dout == 8'h52)
                    rs_released <= 1'b1;
            end
        end
    end

    // ---------------- observation ----------------
    int         os_t[$];
    logic [7:0] os_b[$];
    logic       os_s[$];
    int         or_t[$];
    logic [7:0] or_b[$];
    int         od_t[$];
    logic       od_e[$];

    // ---------------- reference model ----------------
    // A frame is a sequence of slots: byte k is taken in the later of (its
    // LOAD opening, first cycle the source offers it) and strobed one cycle later.
    int         es_t[17];
    logic [7:0] es_b[17];
    int         er_t[16];
    logic [7:0] er_b[16];
    int         ed_t;

    task automatic model(input logic [7:0] cmd, input int len,
                         input logic [7:0] pl[16], input int st[16]);
        int prev_s, h, avail;
        es_t[0] = 1;
        es_b[0] = cmd;
        prev_s  = 1;
        h       = 0;
        for (int k = 0; k < len; k++) begin
            avail = (k == 0) ? st[0] : h + 1 + st[k];
            h     = max2(prev_s + G + 1, avail);
            es_t[k+1] = h + 1;
            es_b[k+1] = pl[k];
            er_t[k]   = h + 3;
            er_b[k]   = resp_byte(cmd, k, pl[k]);
            prev_s    = h + 1;
        end
        ed_t = prev_s + G + 2;
    endtask

    // ---------------- frame driver ----------------
    // Times are in cycles relative to the request-accept cycle (t = 0).
    task automatic run_frame(input logic [7:0] cmd, input int len,
                             input logic [7:0] pl[16], input int st[16]);
        int bi, hold;
        bit fin;
        os_t.delete(); os_b.delete(); os_s.delete();
        or_t.delete(); or_b.delete(); od_t.delete(); od_e.delete();
        @(negedge clk);
        chk("req_ready_idle", int'(sif.req_ready), 1);
        sif.req_valid = 1'b1;
        sif.req_cmd   = cmd;
        sif.req_len   = len[3:0];
        bi   = 0;
        hold = st[0];
        fin  = 1'b0;
        for (int t = 0; t < 2000 && !fin; t++) begin
            if (t > 0) @(negedge clk);
            if (sif.bus_strobe) begin
                os_t.push_back(t); os_b.push_back(sif.bus_dout); os_s.push_back(sif.bus_start);
            end
            if (sif.rd_valid) begin
                or_t.push_back(t); or_b.push_back(sif.rd_data);
            end
            if (sif.done) begin
                od_t.push_back(t); od_e.push_back(sif.err); fin = 1'b1;
            end
            if (t == 1) sif.req_valid = 1'b0;
            if (bi < len) begin
                if (hold > 0) begin
                    sif.wr_valid = 1'b0;
                    hold--;
                end else begin
                    sif.wr_valid = 1'b1;
                    sif.wr_data  = pl[bi];
                    if (sif.wr_ready) begin
                        bi++;
                        hold = (bi < len) ? st[bi] : 0;
                    end
                end
            end else begin
                sif.wr_valid = 1'b0;
            end
        end
        sif.wr_valid  = 1'b0;
        sif.req_valid = 1'b0;
    endtask

    task automatic run_and_check(input string tag, input logic [7:0] cmd, input int len,
                                 input logic [7:0] pl[16], input int st[16]);
        run_frame(cmd, len, pl, st);
        model(cmd, len, pl, st);
        chk({tag, "_strobe_cnt"}, os_t.size(), len + 1);
        for (int k = 0; k <= len && k < os_t.size(); k++) begin
            chk($sformatf("%s_strobe%0d_t", tag, k), os_t[k], es_t[k]);
            chk($sformatf("%s_strobe%0d_start", tag, k), int'(os_s[k]), (k == 0) ? 1 : 0);
            chk($sformatf("%s_strobe%0d_byte", tag, k), int'(os_b[k]), int'(es_b[k]));
        end
        chk({tag, "_rd_cnt"}, or_t.size(), len);
        for (int k = 0; k < len && k < or_t.size(); k++) begin
            chk($sformatf("%s_rd%0d_t", tag, k), or_t[k], er_t[k]);
            chk($sformatf("%s_rd%0d_data", tag, k), int'(or_b[k]), int'(er_b[k]));
        end
        chk({tag, "_done_cnt"}, od_t.size(), 1);
        if (od_t.size() > 0) begin
            chk({tag, "_done_t"}, od_t[0], ed_t);
            chk({tag, "_err"}, int'(od_e[0]), 0);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_req_ready"},  int'(sif.req_ready), 1);
        chk({tag, "_wr_ready"},   int'(sif.wr_ready), 0);
        chk({tag, "_rd_valid"},   int'(sif.rd_valid), 0);
        chk({tag, "_rd_data"},    int'(sif.rd_data), 0);
        chk({tag, "_done"},       int'(sif.done), 0);
        chk({tag, "_err"},        int'(sif.err), 0);
        chk({tag, "_bus_strobe"}, int'(sif.bus_strobe), 0);
        chk({tag, "_bus_start"},  int'(sif.bus_start), 0);
        chk({tag, "_bus_dout"},   int'(sif.bus_dout), 0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [7:0]      cmd;
        int              len;
        logic [2:0][7:0] pl;
        int              stall1;   // cycles wr_valid stays low before byte index 1
        int              done_t;
        logic [2:0][7:0] rd;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] cmd, input int len,
                                input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
                                input int stall1, input int done_t,
                                input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2);
        vec_t v;
        v.cmd = cmd; v.len = len; v.stall1 = stall1; v.done_t = done_t;
        v.pl[0] = p0; v.pl[1] = p1; v.pl[2] = p2;
        v.rd[0] = r0; v.rd[1] = r1; v.rd[2] = r2;
        return v;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached (%0d compared so far)", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl[4];
        logic [7:0] pl[16];
        int         st[16];
        int         dt, de, npay, nrd;

        tbl[0] = mk(CMD_STATUS, 3, 8'h00, 8'h00, 8'h00,  0, 25, 8'h5c, 8'h42, 8'h02);
        tbl[1] = mk(CMD_CONFIG, 2, 8'h52, 8'h00, 8'h00,  0, 19, 8'h52, 8'h00, 8'h00);
        tbl[2] = mk(CMD_INT,    0, 8'h00, 8'h00, 8'h00,  0,  7, 8'h00, 8'h00, 8'h00);
        tbl[3] = mk(CMD_LEDS,   3, 8'h11, 8'h22, 8'h33, 20, 40, 8'h11, 8'h22, 8'h33);

        reset_n       = 1'b0;
        sif.req_valid = 1'b0;
        sif.req_cmd   = 8'h00;
        sif.req_len   = 4'd0;
        sif.wr_valid  = 1'b0;
        sif.wr_data   = 8'h00;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 16; k++) begin
                pl[k] = (k < 3) ? tbl[i].pl[k] : 8'h00;
                st[k] = 0;
            end
            st[1] = tbl[i].stall1;
            run_and_check($sformatf("tbl%0d", i), tbl[i].cmd, tbl[i].len, pl, st);
            if (od_t.size() > 0) chk($sformatf("tbl%0d_done_abs", i), od_t[0], tbl[i].done_t);
            for (int k = 0; k < tbl[i].len && k < or_b.size(); k++)
                chk($sformatf("tbl%0d_rd%0d_abs", i, k), int'(or_b[k]), int'(tbl[i].rd[k]));
            if (tbl[i].cmd == CMD_CONFIG) chk("cfg_released", int'(rs_released), 1);
        end

        // Reset while waiting out the gap after payload strobe 1 (t = 7).
        @(negedge clk);
        sif.req_valid = 1'b1;
        sif.req_cmd   = CMD_STATUS;
        sif.req_len   = 4'd3;
        sif.wr_valid  = 1'b1;
        sif.wr_data   = 8'ha5;
        for (int t = 1; t <= 9; t++) begin
            @(negedge clk);
            if (t == 1) sif.req_valid = 1'b0;
        end
        chk("prerst_rd_valid", int'(sif.rd_valid), 1);
        chk("prerst_rd_data", int'(sif.rd_data), 8'h5c);
        reset_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        sif.wr_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 16; k++) begin pl[k] = 8'h00; st[k] = 0; end
        run_and_check("postrst", CMD_STATUS, 3, pl, st);
        if (or_b.size() == 3) begin
            chk("postrst_b0", int'(or_b[0]), 8'h5c);
            chk("postrst_b1", int'(or_b[1]), 8'h42);
            chk("postrst_b2", int'(or_b[2]), 8'h02);
        end

`ifdef SYSCTRL_INIT_TIMEOUT_EN
        // Payload source never offers a byte: abort after TMO cycles in LOAD.
        @(negedge clk);
        chk("tmo_req_ready", int'(sif.req_ready), 1);
        sif.req_valid = 1'b1;
        sif.req_cmd   = CMD_LEDS;
        sif.req_len   = 4'd2;
        sif.wr_valid  = 1'b0;
        dt = -1; de = 0; npay = 0; nrd = 0;
        for (int t = 0; t < 200 && dt < 0; t++) begin
            if (t > 0) @(negedge clk);
            if (t == 1) sif.req_valid = 1'b0;
            if (sif.bus_strobe && !sif.bus_start) npay++;
            if (sif.rd_valid) nrd++;
            if (sif.done) begin dt = t; de = int'(sif.err); end
        end
        chk("tmo_done_t", dt, G + 2 + TMO);
        chk("tmo_err", de, 1);
        chk("tmo_payload_strobes", npay, 0);
        repeat (4) begin
            @(negedge clk);
            if (sif.rd_valid) nrd++;
        end
        chk("tmo_rd_cnt", nrd, 0);
`endif

        // Randomized frames against the reference model.
        for (int n = 0; n < 30; n++) begin
            logic [7:0] cmd;
            int         len;
            cmd = 8'($urandom_range(0, 6));
            len = int'($urandom_range(0, 15));
            for (int k = 0; k < 16; k++) begin
                pl[k] = 8'($urandom);
                st[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12))
                                                    : int'($urandom_range(0, 2));
            end
            run_and_check($sformatf("rnd%0d", n), cmd, len, pl, st);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
